// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: FSM state encoding, default geometry and the
// key-index helper used by the key schedule.
package rc4_pkg;
    localparam int RC4_W       = 8;
    localparam int RC4_KEY_MAX = 32;
    localparam int RC4_DROP    = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYLOAD,
        ST_INIT,
        ST_KSA,
        ST_DROP,
        ST_STREAM
    } state_t;

    // Key symbol used by KSA iteration i for a key of len symbols.
    function automatic int unsigned key_index(input int unsigned i, input int unsigned len);
        return (len == 32'd0) ? 32'd0 : (i % len);
    endfunction
endpackage

// File: rtl/rc4_sbox.sv
// RC4 permutation table: three combinational reads, single-cycle two-entry
// swap and a sequential init-write port.
module rc4_sbox #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic [W-1:0] addr_a,
    input  logic [W-1:0] addr_b,
    input  logic [W-1:0] addr_t,
    output logic [W-1:0] rd_a,
    output logic [W-1:0] rd_b,
    output logic [W-1:0] rd_t,
    input  logic         swap_en,
    input  logic         init_en,
    input  logic [W-1:0] init_addr,
    input  logic [W-1:0] init_data
);
    logic [W-1:0] mem [2**W];

    assign rd_a = mem[addr_a];
    assign rd_b = mem[addr_b];
    assign rd_t = mem[addr_t];

    // When addr_a == addr_b both writes carry the same value, so the swap is a no-op.
    always_ff @(posedge clk) begin
        if (init_en) begin
            mem[init_addr] <= init_data;
        end else if (swap_en) begin
            mem[addr_a] <= rd_b;
            mem[addr_b] <= rd_a;
        end
    end
endmodule

// File: rtl/rc4_stream.sv
// RC4 stream cipher: key capture, S-box init, KSA, optional keystream drop,
// then a 1-cycle-latency XOR stream with ready/valid handshaking.
module rc4_stream
    import rc4_pkg::*;
#(
    parameter int W       = RC4_W,
    parameter int KEY_MAX = RC4_KEY_MAX,
    parameter int DROP    = RC4_DROP
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [W-1:0] key_in,
    input  logic         din_valid,
    input  logic [W-1:0] din,
    output logic         din_ready,
    output logic         dout_valid,
    output logic [W-1:0] dout,
    input  logic         dout_ready,
    output logic         ks_ready
);
    localparam int LW  = $clog2(KEY_MAX + 1);
    localparam int KIW = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
    localparam int DCW = (DROP > 1) ? $clog2(DROP) : 1;

    state_t         state;
    logic           rst_meta, rst_sync;
    logic [W-1:0]   i, j;
    logic [LW-1:0]  len;
    logic [DCW-1:0] drop_cnt;
    logic [W-1:0]   key_mem [KEY_MAX];

    logic [W-1:0]   i_nxt, addr_a, addr_b, addr_t, rd_a, rd_b, rd_t;
    logic [W-1:0]   key_sym, j_ksa, j_prga, ks;
    logic [KIW-1:0] key_waddr;
    logic           abort, accept, swap_en, init_en, key_we;

    // Assertion is immediate; release is retimed to clk through two flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) {rst_sync, rst_meta} <= 2'b00;
        else      {rst_sync, rst_meta} <= {rst_meta, 1'b1};
    end

    assign abort   = key_valid && (state != ST_KEYLOAD);
    assign i_nxt   = i + 1'b1;
    assign key_sym = key_mem[KIW'(key_index(32'(i), 32'(len)))];
    assign j_ksa   = j + rd_a + key_sym;
    assign j_prga  = j + rd_a;
    assign addr_a  = (state == ST_KSA) ? i : i_nxt;
    assign addr_b  = (state == ST_KSA) ? j_ksa : j_prga;
    assign addr_t  = rd_a + rd_b;

    // Table reads are pre-swap; forward the swapped entries when t hits them.
    assign ks = (addr_t == addr_a) ? rd_b :
                (addr_t == addr_b) ? rd_a : rd_t;

    assign ks_ready  = (state == ST_STREAM);
    assign din_ready = (state == ST_STREAM) && (!dout_valid || dout_ready);
    assign accept    = din_valid && din_ready;
    assign swap_en   = !abort && ((state == ST_KSA) || (state == ST_DROP) ||
                                  ((state == ST_STREAM) && accept));
    assign init_en   = !abort && (state == ST_INIT);
    assign key_we    = abort || (key_valid && (state == ST_KEYLOAD) && (len < LW'(KEY_MAX)));
    assign key_waddr = abort ? '0 : KIW'(len);

    rc4_sbox #(.W(W)) u_sbox (
        .clk       (clk),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .addr_t    (addr_t),
        .rd_a      (rd_a),
        .rd_b      (rd_b),
        .rd_t      (rd_t),
        .swap_en   (swap_en),
        .init_en   (init_en),
        .init_addr (i),
        .init_data (i)
    );

    always_ff @(posedge clk) begin
        if (key_we) key_mem[key_waddr] <= key_in;
    end

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            state      <= ST_IDLE;
            i          <= '0;
            j          <= '0;
            len        <= '0;
            drop_cnt   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (abort) begin
                dout_valid <= 1'b0;
            end else if (accept) begin
                dout       <= din ^ ks;
                dout_valid <= 1'b1;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end

            if (abort) begin
                state <= ST_KEYLOAD;
                len   <= LW'(1);
                i     <= '0;
                j     <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: ;
                    ST_KEYLOAD: begin
                        if (key_valid) begin
                            if (len < LW'(KEY_MAX)) len <= len + 1'b1;
                        end else begin
                            state <= ST_INIT;
                            i     <= '0;
                        end
                    end
                    ST_INIT: begin
                        i <= i_nxt;
                        if (i == '1) begin
                            state <= ST_KSA;
                            j     <= '0;
                        end
                    end
                    ST_KSA: begin
                        i <= i_nxt;
                        j <= j_ksa;
                        if (i == '1) begin
                            j        <= '0;
                            drop_cnt <= '0;
                            state    <= (DROP > 0) ? ST_DROP : ST_STREAM;
                        end
                    end
                    ST_DROP: begin
                        i        <= i_nxt;
                        j        <= j_prga;
                        drop_cnt <= drop_cnt + 1'b1;
                        if (drop_cnt == DCW'(DROP - 1)) state <= ST_STREAM;
                    end
                    ST_STREAM: begin
                        if (accept) begin
                            i <= i_nxt;
                            j <= j_prga;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rc4_stream.sv
// Directed bench for rc4_stream: known RC4 vectors, rekey abort, backpressure,
// key saturation, RC4-drop3 and asynchronous reset.
module tb_rc4_stream;
    typedef logic [7:0] bq_t [$];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       kv   [2];
    logic [7:0] ki   [2];
    logic       dv   [2];
    logic [7:0] di   [2];
    logic       drdy [2];
    logic       ov   [2];
    logic [7:0] od   [2];
    logic       ordy [2];
    logic       ksr  [2];
    int         n_chk  = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    rc4_stream #(.W(8), .KEY_MAX(32), .DROP(0)) dut0 (
        .clk(clk), .rst(rst), .key_valid(kv[0]), .key_in(ki[0]),
        .din_valid(dv[0]), .din(di[0]), .din_ready(drdy[0]),
        .dout_valid(ov[0]), .dout(od[0]), .dout_ready(ordy[0]), .ks_ready(ksr[0])
    );

    rc4_stream #(.W(8), .KEY_MAX(32), .DROP(3)) dut1 (
        .clk(clk), .rst(rst), .key_valid(kv[1]), .key_in(ki[1]),
        .din_valid(dv[1]), .din(di[1]), .din_ready(drdy[1]),
        .dout_valid(ov[1]), .dout(od[1]), .dout_ready(ordy[1]), .ks_ready(ksr[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
        return q;
    endfunction

    task automatic send_key(input int d, input bq_t q);
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            kv[d] = 1'b1;
            ki[d] = q[k];
        end
        @(negedge clk);
        kv[d] = 1'b0;
    endtask

    task automatic wait_ks(input int d, output int cyc);
        cyc = 0;
        while (cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ksr[d]) break;
        end
        chk("ks_ready_reached", 32'(ksr[d]), 32'd1);
    endtask

    task automatic load_key(input int d, input bq_t q, output int cyc);
        send_key(d, q);
        wait_ks(d, cyc);
    endtask

    // Streams din_q back to back; optionally blocks dout_ready for 5 cycles at index stall.
    task automatic stream(input int d, input bq_t din_q, input bq_t exp_q,
                          input string tag, input int stall);
        for (int k = 0; k < din_q.size(); k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk($sformatf("%s_vld[%0d]", tag, k - 1), 32'(ov[d]), 32'd1);
                chk($sformatf("%s_dout[%0d]", tag, k - 1), 32'(od[d]), 32'(exp_q[k - 1]));
            end
            dv[d] = 1'b1;
            di[d] = din_q[k];
            if (k == stall) begin
                ordy[d] = 1'b0;
                #1;
                repeat (5) begin
                    @(negedge clk);
                    chk($sformatf("%s_hold_dout", tag), 32'(od[d]), 32'(exp_q[k - 1]));
                    chk($sformatf("%s_hold_vld", tag), 32'(ov[d]), 32'd1);
                    chk($sformatf("%s_hold_rdy", tag), 32'(drdy[d]), 32'd0);
                end
                ordy[d] = 1'b1;
            end
            #1;
            chk($sformatf("%s_din_ready[%0d]", tag, k), 32'(drdy[d]), 32'd1);
        end
        @(negedge clk);
        chk($sformatf("%s_vld_last", tag), 32'(ov[d]), 32'd1);
        chk($sformatf("%s_dout_last", tag), 32'(od[d]), 32'(exp_q[exp_q.size() - 1]));
        dv[d] = 1'b0;
        @(negedge clk);
        chk($sformatf("%s_vld_clear", tag), 32'(ov[d]), 32'd0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_dout0"}, 32'(od[0]), 32'd0);
        chk({tag, "_vld0"},  32'(ov[0]), 32'd0);
        chk({tag, "_rdy0"},  32'(drdy[0]), 32'd0);
        chk({tag, "_ks0"},   32'(ksr[0]), 32'd0);
        chk({tag, "_dout1"}, 32'(od[1]), 32'd0);
        chk({tag, "_ks1"},   32'(ksr[1]), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bq_t pt, v1_exp, v2_exp, ks_exp, z10, z3, z4, e5a, e5b, longkey;

        for (int d = 0; d < 2; d++) begin
            kv[d] = 1'b0; ki[d] = 8'h00; dv[d] = 1'b0; di[d] = 8'h00; ordy[d] = 1'b1;
        end
        pt     = str2q("Plaintext");
        v1_exp = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        v2_exp = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
        ks_exp = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        e5a    = '{8'h81, 8'hB7, 8'h34};
        e5b    = '{8'hCA, 8'h72, 8'hA7, 8'h19};
        for (int k = 0; k < 10; k++) z10.push_back(8'h00);
        for (int k = 0; k < 3; k++)  z3.push_back(8'h00);
        for (int k = 0; k < 4; k++)  z4.push_back(8'h00);
        longkey = str2q("WikiWikiWikiWikiWikiWikiWikiWikiXQZJRVMT");

        #12;
        reset_checks("reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // V1
        load_key(0, str2q("Key"), cyc);
        chk("v1_ks_cycles", 32'(cyc), 32'd513);
        stream(0, pt, v1_exp, "v1", -1);

        // V2, then rekey while a symbol is in flight and dout_ready is low
        load_key(0, str2q("Wiki"), cyc);
        stream(0, str2q("pedia"), v2_exp, "v2", -1);
        @(negedge clk);
        dv[0] = 1'b1; di[0] = 8'h00;
        @(negedge clk);
        dv[0] = 1'b0; ordy[0] = 1'b0;
        chk("v2_inflight_vld", 32'(ov[0]), 32'd1);
        kv[0] = 1'b1; ki[0] = "K";
        @(negedge clk);
        chk("v2_abort_vld", 32'(ov[0]), 32'd0);
        chk("v2_abort_ks", 32'(ksr[0]), 32'd0);
        ki[0] = "e";
        @(negedge clk);
        ki[0] = "y";
        @(negedge clk);
        kv[0] = 1'b0; ordy[0] = 1'b1;
        wait_ks(0, cyc);
        chk("v2_rekey_cycles", 32'(cyc), 32'd513);
        stream(0, z10, ks_exp, "v2_rekey", -1);

        // V3
        load_key(0, str2q("Key"), cyc);
        stream(0, pt, v1_exp, "v3", 4);

        // V4: symbols beyond 32 are ignored, leaving Wiki x8 which schedules like "Wiki"
        load_key(0, longkey, cyc);
        stream(0, str2q("pedia"), v2_exp, "v4", -1);

        // V5: drop3 skips EB 9F 77; idle gap must not advance the keystream
        load_key(1, str2q("Key"), cyc);
        chk("v5_ks_cycles", 32'(cyc), 32'd516);
        stream(1, z3, e5a, "v5a", -1);
        repeat (4) @(negedge clk);
        stream(1, z4, e5b, "v5b", -1);

        // V6: reset mid-KSA
        send_key(0, str2q("Key"));
        repeat (300) @(negedge clk);
        chk("v6_ksa_dout_held", 32'(od[0]), 32'h20);
        chk("v6_ksa_not_ready", 32'(ksr[0]), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        reset_checks("v6_ksa_rst");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // V6: reset mid-STREAM with a valid output pending
        load_key(0, str2q("Key"), cyc);
        @(negedge clk);
        dv[0] = 1'b1; di[0] = "P";
        @(negedge clk);
        dv[0] = 1'b0;
        chk("v6_stream_vld", 32'(ov[0]), 32'd1);
        chk("v6_stream_dout", 32'(od[0]), 32'hBB);
        #2;
        rst = 1'b0;
        #1;
        reset_checks("v6_stream_rst");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        load_key(0, str2q("Key"), cyc);
        stream(0, pt, v1_exp, "v6_reload", -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rc4_stream.md
RC4_STREAM -- requirements
Module: rc4_stream

Interface
REQ-001 The block SHALL have parameters, one per line:
- W, 8, symbol width in bits; S-box has 2^W entries.
- KEY_MAX, 32, maximum key length in symbols.
- DROP, 0, number of initial keystream symbols discarded before data is processed (RC4-dropN).
REQ-002 The block SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- key_valid  in  1  high while key symbols are presented, one per cycle.
- key_in  in  W  key symbol.
- din_valid  in  1  input symbol valid.
- din  in  W  plaintext or ciphertext symbol (RC4 is symmetric; no mode pin).
- din_ready  out  1  block accepts din this cycle.
- dout_valid  out  1  output symbol valid.
- dout  out  W  din XOR keystream.
- dout_ready  in  1  downstream accepts dout.
- ks_ready  out  1  key schedule and drop complete; stream phase active.

Function
REQ-003 The FSM SHALL have states IDLE, KEYLOAD, INIT, KSA, DROP, STREAM.
REQ-004 IDLE->KEYLOAD on key_valid=1; the symbol present on that cycle is key[0].
REQ-005 KEYLOAD SHALL store one symbol per key_valid cycle; length L saturates at KEY_MAX, and further symbols are ignored.
REQ-006 KEYLOAD->INIT on the first cycle key_valid=0; L>=1 is guaranteed by construction.
REQ-007 INIT SHALL write S[i]=i, one entry per cycle, 2^W cycles; then ->KSA with i=0, j=0.
REQ-008 KSA SHALL perform one iteration per cycle, 2^W cycles:
- j=j+S[i]+key[i mod L], mod 2^W.
- swap S[i],S[j]; the i==j swap is a no-op.
REQ-009 After KSA, i=j=0; ->DROP if DROP>0, else ->STREAM.
REQ-010 DROP SHALL generate and discard one keystream symbol per cycle for DROP cycles, then ->STREAM.
REQ-011 PRGA step, all mod 2^W:
- i'=i+1; j'=j+S[i']; swap S[i'],S[j'].
- t=S_old[i']+S_old[j'].
- keystream k = S_new[t], with forwarding in the same cycle: t==i' gives S_old[j']; t==j' gives S_old[i'].
REQ-012 din_ready SHALL be 1 only in STREAM and only when dout_valid=0 or dout_ready=1.
REQ-013 On a din_valid & din_ready cycle, one PRGA step SHALL occur, and dout <= din XOR k and dout_valid <= 1 at the next edge. Latency is 1 cycle and throughput is 1 symbol/cycle.
REQ-014 The keystream SHALL NOT advance on cycles with no accepted input.
REQ-015 dout_valid SHALL clear when dout_ready=1 and no new symbol is accepted.
REQ-016 dout and dout_valid SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-017 key_valid=1 in any state other than KEYLOAD SHALL abort the current operation and enter KEYLOAD with that symbol as key[0].
- In-flight dout_valid is cleared at the same edge.
- L restarts at 1.
REQ-018 ks_ready SHALL equal (state==STREAM); din_valid outside STREAM is ignored.
REQ-019 Index arithmetic SHALL wrap modulo 2^W with no overflow flags.

Reset
REQ-020 Assertion of rst (low) SHALL immediately force:
- state=IDLE; i=j=0; L=0.
- dout=0, dout_valid=0, din_ready=0, ks_ready=0.
REQ-021 S-box and key buffer contents SHALL be don't-care after reset; INIT rewrites the S-box before use.
REQ-022 Release SHALL be synchronised to clk; the first active edge after release evaluates IDLE.

Structure
REQ-023 A package rc4_pkg SHALL hold the state enum, default W/KEY_MAX/DROP, and the function computing key index i mod L.
REQ-024 The S-box SHALL be the sub-module rc4_sbox:
- 2^W x W register array.
- Two combinational read ports, plus a third read port for t.
- Single-cycle swap write of two addresses.
- Init-write port.
REQ-025 rc4_stream SHALL contain the FSM, key buffer, i/j/counters, forwarding mux and output register.

Verification
REQ-026 V1: W=8, DROP=0, key "Key" (4B 65 79), din "Plaintext" -> dout BB F3 16 E8 D9 40 AF 0A D3.
REQ-027 V2: key "Wiki", din "pedia" -> dout 10 21 BF 04 20. Then rekey with "Key" mid-stream -> restart per REQ-017, and din of 10 zeros -> dout EB 9F 77 81 B7 34 CA 72 A7 19.
REQ-028 V3: dout_ready held 0 for 5 cycles during V1 -> dout is stable, din_ready=0, and the stream resumes with identical output bytes.
REQ-029 V4: 40-symbol key with KEY_MAX=32 -> output equals that of the first 32 symbols alone.
REQ-030 V5: DROP=3, key "Key", 7 zero inputs -> dout 81 B7 34 CA 72 A7 19. ks_ready rises 2^W+2^W+3 cycles after key_valid falls, plus 1 KEYLOAD-exit cycle.
REQ-031 V6: rst low mid-KSA and mid-STREAM -> outputs are zero immediately. Reload with "Key" -> V1 result.
